logic_op_sequencer: RTL and testbench

LOGIC_OP_SEQUENCER -- requirements
Module: logic_op_sequencer

---
 rtl/logic_op_sequencer_pkg.sv | 26 ++
 rtl/logic_op_sequencer.sv | 152 +++++++++++++++
 tb/tb_logic_op_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_op_sequencer_pkg.sv
// Shared constants for the logic-op sequencer: operand/opcode widths, opcode
// values, FSM state encoding and the opcode legality helper.
package logic_op_sequencer_pkg;

  localparam int OPND_W = 4;
  localparam int OPC_W  = 3;

  localparam logic [OPC_W-1:0] OP_AND  = 3'd0;
  localparam logic [OPC_W-1:0] OP_OR   = 3'd1;
  localparam logic [OPC_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OPC_W-1:0] OP_NAND = 3'd3;
  localparam logic [OPC_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OPC_W-1:0] OP_MAX  = OP_NOR;

  typedef enum logic [1:0] {
    LOAD_OP = 2'd0,
    LOAD_X  = 2'd1,
    LOAD_Y  = 2'd2,
    ISSUE   = 2'd3
  } state_e;

  function automatic logic op_is_legal(input logic [OPC_W-1:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/logic_op_sequencer.sv
// Collects opcode, x and y beats and issues them atomically to a downstream
// logic unit. Define LOGIC_SEQ_ILLEGAL_CHK_EN to drop opcodes above OP_MAX and
// raise the sticky err flag; otherwise every opcode is sequenced and err is 0.
module logic_op_sequencer
  import logic_op_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic [3:0] op_x,
  output logic [3:0] op_y,
  output logic [2:0] op_s,
  output logic       op_valid,
  output logic [7:0] issue_cnt,
  output logic       err
);

  state_e state_q, state_d;

  logic [OPC_W-1:0]  stg_opc_q, stg_opc_d;
  logic [OPND_W-1:0] stg_x_q,   stg_x_d;
  logic [OPND_W-1:0] op_x_q,    op_x_d;
  logic [OPND_W-1:0] op_y_q,    op_y_d;
  logic [OPC_W-1:0]  op_s_q,    op_s_d;
  logic              op_valid_q, op_valid_d;
  logic [7:0]        cnt_q,     cnt_d;

  logic accept;
  logic opc_legal;

  assign accept = in_valid & in_ready;

`ifdef LOGIC_SEQ_ILLEGAL_CHK_EN
  logic err_q, err_d;
  assign opc_legal = op_is_legal(in_data[OPC_W-1:0]);
  assign err       = err_q;
`else
  assign opc_legal = 1'b1;
  assign err       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_OP;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, regardless of block ordering.
      state_q <= state_d;
    end
  end

  // Next-state logic: clr overrides everything, including a coincident beat.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_d = state_q;
    if (clr) begin
      state_d = LOAD_OP;
    end else begin
      case (state_q)
        LOAD_OP: if (accept && opc_legal) state_d = LOAD_X;
        LOAD_X:  if (accept)              state_d = LOAD_Y;
        LOAD_Y:  if (accept)              state_d = ISSUE;
        ISSUE:                            state_d = LOAD_OP;
        default:                          state_d = LOAD_OP;
      endcase
    end
  end

  // Output logic: held low during reset so no beat is taken before the FSM is valid.
  always_comb begin
    in_ready = rst_n && (state_q != ISSUE);
  end

  // Datapath next-state: operands move only on the LOAD_Y accept edge.
  always_comb begin
    stg_opc_d  = stg_opc_q;
    stg_x_d    = stg_x_q;
    op_x_d     = op_x_q;
    op_y_d     = op_y_q;
    op_s_d     = op_s_q;
    op_valid_d = 1'b0;
    cnt_d      = cnt_q;
`ifdef LOGIC_SEQ_ILLEGAL_CHK_EN
    err_d      = err_q;
`endif
    if (clr) begin
      stg_opc_d = '0;
      stg_x_d   = '0;
    end else if (accept) begin
      case (state_q)
        LOAD_OP: begin
          if (opc_legal) begin
            stg_opc_d = in_data[OPC_W-1:0];
          end
`ifdef LOGIC_SEQ_ILLEGAL_CHK_EN
          else begin
            err_d = 1'b1;
          end
`endif
        end
        LOAD_X: stg_x_d = in_data;
        LOAD_Y: begin
          op_s_d     = stg_opc_q;
          op_x_d     = stg_x_q;
          op_y_d     = in_data;
          op_valid_d = 1'b1;
          cnt_d      = cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: staging registers are ordinary flops, not a memory, so they are
  // reset like every other register to keep post-reset behaviour deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_opc_q  <= '0;
      stg_x_q    <= '0;
      op_x_q     <= '0;
      op_y_q     <= '0;
      op_s_q     <= '0;
      op_valid_q <= 1'b0;
      cnt_q      <= '0;
`ifdef LOGIC_SEQ_ILLEGAL_CHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      stg_opc_q  <= stg_opc_d;
      stg_x_q    <= stg_x_d;
      op_x_q     <= op_x_d;
      op_y_q     <= op_y_d;
      op_s_q     <= op_s_d;
      op_valid_q <= op_valid_d;
      cnt_q      <= cnt_d;
`ifdef LOGIC_SEQ_ILLEGAL_CHK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign op_x      = op_x_q;
  assign op_y      = op_y_q;
  assign op_s      = op_s_q;
  assign op_valid  = op_valid_q;
  assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Self-checking bench for logic_op_sequencer: directed scenarios plus random
// traffic against a beat-queue reference model and a downstream logic unit.
module tb_logic_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic [3:0] op_x;
  logic [3:0] op_y;
  logic [2:0] op_s;
  logic       op_valid;
  logic [7:0] issue_cnt;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

`ifdef LOGIC_SEQ_ILLEGAL_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic_op_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .op_x      (op_x),
    .op_y      (op_y),
    .op_s      (op_s),
    .op_valid  (op_valid),
    .issue_cnt (issue_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Downstream logic unit: captures the operand set on the edge ending ISSUE.
  logic [3:0] lu_q = 4'h0;
  always @(posedge clk) begin
    if (op_valid) begin
      case (op_s)
        3'd0:    lu_q <= op_x & op_y;
        3'd1:    lu_q <= op_x | op_y;
        3'd2:    lu_q <= op_x ^ op_y;
        3'd3:    lu_q <= ~(op_x & op_y);
        3'd4:    lu_q <= ~(op_x | op_y);
        default: lu_q <= 4'h0;
      endcase
    end
  end

  // Reference model: beats collected for the current operation, plus an
  // "issuing" flag for the single cycle in which no beat is accepted.
  logic [3:0] beats[$];
  bit         m_issue;
  bit         m_valid;
  logic [2:0] m_s;
  logic [3:0] m_x;
  logic [3:0] m_y;
  logic [7:0] m_cnt;
  bit         m_err;

  task automatic model_reset();
    beats.delete();
    m_issue = 0;
    m_valid = 0;
    m_s     = '0;
    m_x     = '0;
    m_y     = '0;
    m_cnt   = '0;
    m_err   = 0;
  endtask

  task automatic model_edge();
    logic [3:0] first;
    m_valid = 0;
    if (clr) begin
      beats.delete();
      m_issue = 0;
    end else if (m_issue) begin
      m_issue = 0;
    end else if (in_valid) begin
      if (beats.size() == 0 && CHK && in_data[2:0] > 3'd4) begin
        m_err = 1;
      end else begin
        beats.push_back(in_data);
        if (beats.size() == 3) begin
          first   = beats[0];
          m_s     = first[2:0];
          m_x     = beats[1];
          m_y     = beats[2];
          m_valid = 1;
          m_cnt   = m_cnt + 8'd1;
          m_issue = 1;
          beats.delete();
        end
      end
    end
  endtask

  function automatic logic [21:0] dut_vec();
    return {in_ready, op_valid, op_s, op_x, op_y, issue_cnt, err};
  endfunction

  function automatic logic [21:0] model_vec();
    return {~m_issue, m_valid, m_s, m_x, m_y, m_cnt, m_err};
  endfunction

  // Called at a negedge: drive, clock, update model, return to the next negedge.
  task automatic step(input logic v, input logic [3:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    clr      = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    clr      = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'h0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== 22'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h want %h", dut_vec(), 22'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    step(1'b1, 4'h2, 1'b0);
    step(1'b1, 4'hA, 1'b0);
    n_checks++;
    if (op_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_loading: op_valid=%b in_ready=%b want 0/1", op_valid, in_ready);
    end
    step(1'b1, 4'h6, 1'b0);
    n_checks++;
    if ({op_valid, op_s, op_x, op_y, issue_cnt, in_ready} !== {1'b1, 3'd2, 4'hA, 4'h6, 8'd1, 1'b0}) begin
      n_errors++;
      $display("FAIL basic_issue: v=%b s=%0d x=%h y=%h cnt=%0d rdy=%b want 1/2/a/6/1/0",
               op_valid, op_s, op_x, op_y, issue_cnt, in_ready);
    end
    step(1'b0, 4'h0, 1'b0);
    n_checks++;
    if (op_valid !== 1'b0 || in_ready !== 1'b1 || lu_q !== 4'hC) begin
      n_errors++;
      $display("FAIL basic_after_issue: v=%b rdy=%b q=%h want 0/1/c", op_valid, in_ready, lu_q);
    end
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_errors++;
      $display("FAIL basic_model: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_toggle();
    logic [3:0] seq_d[5];
    logic       seq_v[5];
    int         pulses;
    seq_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    seq_d = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h3};
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(seq_v[i], seq_v[i] ? seq_d[i] : 4'($urandom), 1'b0);
      if (op_valid) pulses++;
      if (i < 4) begin
        n_checks++;
        if (op_x !== 4'hA || op_valid !== 1'b0 || in_ready !== 1'b1) begin
          n_errors++;
          $display("FAIL toggle_hold[%0d]: x=%h v=%b rdy=%b want a/0/1", i, op_x, op_valid, in_ready);
        end
      end
    end
    n_checks++;
    if ({op_valid, op_s, op_x, op_y, issue_cnt} !== {1'b1, 3'd0, 4'hF, 4'h3, 8'd2}) begin
      n_errors++;
      $display("FAIL toggle_issue: v=%b s=%0d x=%h y=%h cnt=%0d want 1/0/f/3/2",
               op_valid, op_s, op_x, op_y, issue_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'($urandom), 1'b0);
      if (op_valid) pulses++;
    end
    n_checks++;
    if (pulses !== 1 || lu_q !== 4'h3) begin
      n_errors++;
      $display("FAIL toggle_once: pulses=%0d q=%h want 1/3", pulses, lu_q);
    end
  endtask

  task automatic test_clr();
    step(1'b1, 4'h1, 1'b0);
    step(1'b1, 4'h7, 1'b1);
    n_checks++;
    if ({op_valid, in_ready, op_s, op_x, op_y, issue_cnt} !== {1'b0, 1'b1, 3'd0, 4'hF, 4'h3, 8'd2}) begin
      n_errors++;
      $display("FAIL clr_hold: v=%b rdy=%b s=%0d x=%h y=%h cnt=%0d want 0/1/0/f/3/2",
               op_valid, in_ready, op_s, op_x, op_y, issue_cnt);
    end
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h5, 1'b0);
    n_checks++;
    if (op_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_restart_early: op_valid=%b want 0", op_valid);
    end
    step(1'b1, 4'h9, 1'b0);
    n_checks++;
    if ({op_valid, op_s, op_x, op_y, issue_cnt} !== {1'b1, 3'd3, 4'h5, 4'h9, 8'd3}) begin
      n_errors++;
      $display("FAIL clr_restart: v=%b s=%0d x=%h y=%h cnt=%0d want 1/3/5/9/3",
               op_valid, op_s, op_x, op_y, issue_cnt);
    end
    step(1'b0, 4'h0, 1'b0);
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_errors++;
      $display("FAIL clr_model: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_wrap();
    int pulses;
    pulses = 0;
    apply_reset();
    for (int op = 0; op < 256; op++) begin
      step(1'b1, 4'($urandom_range(0, 4)), 1'b0);
      step(1'b1, 4'($urandom), 1'b0);
      step(1'b1, 4'($urandom), 1'b0);
      if (op_valid) pulses++;
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++;
        $display("FAIL wrap_op[%0d]: got %h want %h", op, dut_vec(), model_vec());
      end
      step(1'b1, 4'($urandom), 1'b0);
      if (op_valid) pulses++;
    end
    n_checks++;
    if (issue_cnt !== 8'd0 || pulses !== 256) begin
      n_errors++;
      $display("FAIL wrap_count: cnt=%0d pulses=%0d want 0/256", issue_cnt, pulses);
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    step(1'b1, 4'h6, 1'b0);
    n_checks++;
    if (err !== CHK || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL illegal_err: err=%b rdy=%b want %b/1", err, in_ready, CHK);
    end
    step(1'b1, 4'h1, 1'b0);
    step(1'b1, 4'h5, 1'b0);
`ifdef LOGIC_SEQ_ILLEGAL_CHK_EN
    n_checks++;
    if (op_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL illegal_dropped: op_valid=%b want 0", op_valid);
    end
    step(1'b1, 4'h3, 1'b0);
    n_checks++;
    if ({op_valid, op_s, op_x, op_y, err} !== {1'b1, 3'd1, 4'h5, 4'h3, 1'b1}) begin
      n_errors++;
      $display("FAIL illegal_issue: v=%b s=%0d x=%h y=%h err=%b want 1/1/5/3/1",
               op_valid, op_s, op_x, op_y, err);
    end
`else
    n_checks++;
    if ({op_valid, op_s, op_x, op_y, err} !== {1'b1, 3'd6, 4'h1, 4'h5, 1'b0}) begin
      n_errors++;
      $display("FAIL illegal_issue: v=%b s=%0d x=%h y=%h err=%b want 1/6/1/5/0",
               op_valid, op_s, op_x, op_y, err);
    end
    step(1'b1, 4'h3, 1'b0);
`endif
    step(1'b0, 4'h0, 1'b0);
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_errors++;
      $display("FAIL illegal_model: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_reset_in_issue();
    apply_reset();
    step(1'b1, 4'h4, 1'b0);
    step(1'b1, 4'hC, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    n_checks++;
    if (op_valid !== 1'b1 || issue_cnt !== 8'd1) begin
      n_errors++;
      $display("FAIL rst_issue_setup: v=%b cnt=%0d want 1/1", op_valid, issue_cnt);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_vec() !== 22'h0) begin
      n_errors++;
      $display("FAIL rst_issue_outputs: got %h want %h", dut_vec(), 22'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b0);
    n_checks++;
    if (issue_cnt !== 8'd0 || op_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_issue_after: cnt=%0d v=%b rdy=%b want 0/0/1", issue_cnt, op_valid, in_ready);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 15) == 0);
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++;
        $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_clr();
    test_wrap();
    test_illegal();
    test_reset_in_issue();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
